// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage.
// Registers the MEM-stage result, extracts and sign/zero-extends load data,
// flags misaligned or illegal loads, gates the register-file write strobe
// and counts retired instructions.
// Optional macro WB_FORWARD_EN adds combinational copies of the write port
// (fwd_valid, fwd_rd, fwd_data) for the decode-stage bypass.
//
// Handshake: there is no back-pressure. A slot is accepted at a posedge when
// mem_valid=1, stall=0 and flush=0; otherwise a bubble is captured.
module wb_stage #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_rd,
    input  logic [1:0]           mem_wb_sel,
    input  logic [2:0]           mem_funct3,
    input  logic [31:0]          mem_alu_result,
    input  logic [31:0]          mem_load_data,
    input  logic [31:0]          mem_pc4,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 WriteEnable,
    output logic [4:0]           rd,
    output logic [31:0]          data,
    output logic                 wb_valid,
    output logic                 load_fault,
    output logic [INSTRET_W-1:0] instret
`ifdef WB_FORWARD_EN
    ,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [31:0]          fwd_data
`endif
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic        fault;
    logic        take;
    logic [31:0] nxt_data;
    logic        nxt_we;

    assign off  = mem_alu_result[1:0];
    assign take = mem_valid && !stall && !flush;

    // Load extraction and fault detection from funct3 and byte offset.
    always_comb begin
        ld_byte  = mem_load_data[7:0];
        ld_half  = mem_load_data[15:0];
        load_val = 32'h0;
        fault    = 1'b0;
        case (off)
            2'd0:    ld_byte = mem_load_data[7:0];
            2'd1:    ld_byte = mem_load_data[15:8];
            2'd2:    ld_byte = mem_load_data[23:16];
            default: ld_byte = mem_load_data[31:24];
        endcase
        if (off[1]) ld_half = mem_load_data[31:16];
        case (mem_funct3)
            3'b000: load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001: begin
                load_val = {{16{ld_half[15]}}, ld_half};
                fault    = off[0];
            end
            3'b010: begin
                load_val = mem_load_data;
                fault    = (off != 2'd0);
            end
            3'b100: load_val = {24'h0, ld_byte};
            3'b101: begin
                load_val = {16'h0, ld_half};
                fault    = off[0];
            end
            default: fault = 1'b1;
        endcase
        // Faults only matter when the result actually comes from memory.
        if (mem_wb_sel != SEL_LOAD) fault = 1'b0;
    end

    // Result mux and write-strobe qualification.
    always_comb begin
        nxt_data = mem_alu_result;
        case (mem_wb_sel)
            SEL_ALU:  nxt_data = mem_alu_result;
            SEL_LOAD: nxt_data = fault ? 32'h0 : load_val;
            SEL_PC4:  nxt_data = mem_pc4;
            default:  nxt_data = mem_alu_result;
        endcase
        // Reserved select still retires but never writes; x0 is never written.
        nxt_we = mem_reg_write && (mem_rd != 5'd0) && !fault &&
                 (mem_wb_sel != 2'b11);
    end

    // Output registers; rd and data hold their last value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            WriteEnable <= 1'b0;
            wb_valid    <= 1'b0;
            load_fault  <= 1'b0;
            rd          <= 5'd0;
            data        <= 32'h0;
        end else if (take) begin
            WriteEnable <= nxt_we;
            wb_valid    <= 1'b1;
            load_fault  <= fault;
            rd          <= mem_rd;
            data        <= nxt_data;
        end else begin
            WriteEnable <= 1'b0;
            wb_valid    <= 1'b0;
            load_fault  <= 1'b0;
        end
    end

    // Retired-instruction counter advances in step with wb_valid rising for a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (take) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid = WriteEnable;
    assign fwd_rd    = rd;
    assign fwd_data  = data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed plus random stimulus for wb_stage with a reference
// model feeding an expected-result queue.
module tb_wb_stage;

  localparam int IW = 8;
  localparam int EW = 1 + 5 + 32 + 1 + 1 + IW;

  logic          clk;
  logic          rst;
  logic          mem_valid;
  logic          mem_reg_write;
  logic [4:0]    mem_rd;
  logic [1:0]    mem_wb_sel;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_alu_result;
  logic [31:0]   mem_load_data;
  logic [31:0]   mem_pc4;
  logic          stall;
  logic          flush;
  logic          write_en;
  logic [4:0]    rd;
  logic [31:0]   data;
  logic          wb_valid;
  logic          load_fault;
  logic [IW-1:0] instret;
`ifdef WB_FORWARD_EN
  logic          fwd_valid;
  logic [4:0]    fwd_rd;
  logic [31:0]   fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];

  // model state
  logic [4:0]    m_rd   = 5'd0;
  logic [31:0]   m_data = 32'h0;
  logic [IW-1:0] m_cnt  = '0;

  wb_stage #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc4(mem_pc4), .stall(stall), .flush(flush),
    .WriteEnable(write_en), .rd(rd), .data(data), .wb_valid(wb_valid),
    .load_fault(load_fault), .instret(instret)
`ifdef WB_FORWARD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: computes the expected registered outputs for the
  // inputs currently driven and pushes them to the queue
  task automatic model_push();
    logic          e_we, e_v, e_f;
    logic [31:0]   val;
    logic [7:0]    b;
    logic [15:0]   h;
    logic [1:0]    o;
    e_we = 1'b0; e_v = 1'b0; e_f = 1'b0;
    if (rst) begin
      m_rd = 5'd0; m_data = 32'h0; m_cnt = '0;
    end else if (mem_valid && !stall && !flush) begin
      o = mem_alu_result[1:0];
      b = 8'(mem_load_data >> (8 * o));
      h = 16'(mem_load_data >> (16 * o[1]));
      val = 32'h0;
      if (mem_wb_sel == 2'b01) begin
        if (mem_funct3 == 3'b000) val = {{24{b[7]}}, b};
        else if (mem_funct3 == 3'b100) val = {24'h0, b};
        else if (mem_funct3 == 3'b001) begin val = {{16{h[15]}}, h}; e_f = o[0]; end
        else if (mem_funct3 == 3'b101) begin val = {16'h0, h}; e_f = o[0]; end
        else if (mem_funct3 == 3'b010) begin val = mem_load_data; e_f = (o != 2'd0); end
        else e_f = 1'b1;
        if (e_f) val = 32'h0;
      end else if (mem_wb_sel == 2'b10) val = mem_pc4;
      else val = mem_alu_result;
      e_v  = 1'b1;
      e_we = mem_reg_write && (mem_rd != 5'd0) && !e_f && (mem_wb_sel != 2'b11);
      m_rd = mem_rd; m_data = val; m_cnt = m_cnt + 1'b1;
    end
    exp_q.push_back({e_we, m_rd, m_data, e_v, e_f, m_cnt});
  endtask

  // driver: apply one MEM slot at the negedge and record its expectation
  task automatic drive(input logic v, input logic rw, input logic [4:0] r,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc4, input logic st, input logic fl);
    @(negedge clk);
    mem_valid = v; mem_reg_write = rw; mem_rd = r; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld;
    mem_pc4 = pc4; stall = st; flush = fl;
    model_push();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: after the edge, pop one expectation and compare every output
  task automatic step();
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk("write_en",   64'(write_en),   64'(e[EW-1]));
      chk("rd",         64'(rd),         64'(e[EW-2 -: 5]));
      chk("data",       64'(data),       64'(e[EW-7 -: 32]));
      chk("wb_valid",   64'(wb_valid),   64'(e[IW+1]));
      chk("load_fault", 64'(load_fault), 64'(e[IW]));
      chk("instret",    64'(instret),    64'(e[IW-1:0]));
    end
  endtask

  localparam logic [31:0] LD = 32'h80FF_7F01;

  initial begin
    rst = 1'b1;
    drive(1, 1, 5'd7, 2'b00, 3'b000, 32'h99, 0, 0, 0, 0); step();
    chk("reset_instret", 64'(instret), 64'd0);
    chk("reset_we", 64'(write_en), 64'd0);
    rst = 1'b0;

    // ALU path
    drive(1, 1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 0, 0, 0, 0); step();
    chk("alu_data", 64'(data), 64'h1234);
    chk("alu_we", 64'(write_en), 64'd1);
    chk("alu_instret", 64'(instret), 64'd1);

    // load extraction
    drive(1, 1, 5'd6, 2'b01, 3'b000, 32'h3, LD, 0, 0, 0); step();
    chk("lb_off3", 64'(data), 64'hFFFF_FF80);
    drive(1, 1, 5'd6, 2'b01, 3'b100, 32'h3, LD, 0, 0, 0); step();
    chk("lbu_off3", 64'(data), 64'h0000_0080);
    drive(1, 1, 5'd6, 2'b01, 3'b001, 32'h2, LD, 0, 0, 0); step();
    chk("lh_off2", 64'(data), 64'hFFFF_80FF);
    drive(1, 1, 5'd6, 2'b01, 3'b101, 32'h0, LD, 0, 0, 0); step();
    chk("lhu_off0", 64'(data), 64'h0000_7F01);
    drive(1, 1, 5'd6, 2'b01, 3'b010, 32'h0, LD, 0, 0, 0); step();
    chk("lw_off0", 64'(data), 64'h80FF_7F01);

    // misaligned LW: one-cycle fault pulse
    drive(1, 1, 5'd8, 2'b01, 3'b010, 32'h0000_0102, LD, 0, 0, 0); step();
    chk("fault_pulse", 64'(load_fault), 64'd1);
    chk("fault_data", 64'(data), 64'd0);
    chk("fault_instret", 64'(instret), 64'd7);
    drive(0, 0, 5'd0, 2'b00, 3'b000, 0, 0, 0, 0, 0); step();
    chk("fault_cleared", 64'(load_fault), 64'd0);
    // other fault codes and misaligned halves
    drive(1, 1, 5'd9, 2'b01, 3'b011, 32'h0, LD, 0, 0, 0); step();
    drive(1, 1, 5'd9, 2'b01, 3'b110, 32'h0, LD, 0, 0, 0); step();
    drive(1, 1, 5'd9, 2'b01, 3'b111, 32'h0, LD, 0, 0, 0); step();
    drive(1, 1, 5'd9, 2'b01, 3'b001, 32'h1, LD, 0, 0, 0); step();
    drive(1, 1, 5'd9, 2'b01, 3'b101, 32'h3, LD, 0, 0, 0); step();
    // illegal funct3 is harmless on a non-load select
    drive(1, 1, 5'd9, 2'b00, 3'b111, 32'h5, LD, 0, 0, 0); step();

    // rd=0 with PC+4, and reserved select
    drive(1, 1, 5'd0, 2'b10, 3'b000, 0, 0, 32'h44, 0, 0); step();
    chk("rd0_we", 64'(write_en), 64'd0);
    chk("rd0_valid", 64'(wb_valid), 64'd1);
    drive(1, 1, 5'd3, 2'b11, 3'b000, 32'hABCD, 0, 0, 0, 0); step();

    // stall, flush, both: three bubbles holding rd/data
    drive(1, 1, 5'd4, 2'b00, 3'b000, 32'h1, 0, 0, 1, 0); step();
    drive(1, 1, 5'd4, 2'b00, 3'b000, 32'h2, 0, 0, 0, 1); step();
    drive(1, 1, 5'd4, 2'b00, 3'b000, 32'h3, 0, 0, 1, 1); step();
    chk("bubble_hold_data", 64'(data), 64'hABCD);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
            $urandom, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      step();
    end

    // drive the counter to all-ones, then one retire wraps it
    for (int i = 0; i < 300 && m_cnt != '1; i++) begin
      drive(1, 1, 5'($urandom_range(1, 31)), 2'b00, 3'b000, $urandom, 0, 0, 0, 0);
      step();
    end
    chk("instret_max", 64'(instret), 64'hFF);
    drive(1, 1, 5'd2, 2'b00, 3'b000, 32'h77, 0, 0, 0, 0); step();
    chk("instret_wrap", 64'(instret), 64'd0);

    // reset while a valid instruction sits in WB
    drive(1, 1, 5'd12, 2'b00, 3'b000, 32'h55, 0, 0, 0, 0); step();
    rst = 1'b1;
    drive(1, 1, 5'd13, 2'b00, 3'b000, 32'h66, 0, 0, 0, 0); step();
    chk("rst_we", 64'(write_en), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    rst = 1'b0;
    drive(0, 0, 5'd0, 2'b00, 3'b000, 0, 0, 0, 0, 0); step();
    chk("post_rst_instret", 64'(instret), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
